// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and counter helpers for the branch predictor
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bp_state_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != ST) n = ctr_t'(c + 2'd1);
        end else begin
            if (c != SNT) n = ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

    function automatic logic ctr_is_taken(input ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/bp_stat_counter.sv
// rtl/bp_stat_counter.sv - saturating event counter cleared only by reset
module bp_stat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters and clear sweep
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_en,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             update_en,
    input  logic [PC_W-1:0]  update_pc,
    input  logic             update_taken,
    input  logic [PC_W-1:0]  update_target,
    input  logic             update_mispred,
    input  logic             inv_req,
    output logic             busy,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    // Storage is deliberately unreset so it can map onto RAM; the sweep clears it.
    logic              valid_mem  [ENTRIES];
    logic [TAG_W-1:0]  tag_mem    [ENTRIES];
    logic [PC_W-3:0]   target_mem [ENTRIES];
    ctr_t              ctr_mem    [ENTRIES];

    bp_state_t         state, state_n;
    logic [IDX_W-1:0]  clr_idx, clr_idx_n;

    logic [IDX_W-1:0]  lu_idx, up_idx;
    logic [TAG_W-1:0]  lu_tag, up_tag;
    logic              up_hit;
    logic              unused_bits;

    assign lu_idx = lookup_pc[IDX_W+1:2];
    assign lu_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[PC_W-1:IDX_W+2];
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], update_target[1:0]};

    assign busy = (state == CLEAR) || !rst;

    // Lookup reads pre-update contents; a same-cycle update is seen next cycle.
    always_comb begin
        pred_hit    = lookup_en && !busy && valid_mem[lu_idx] && (tag_mem[lu_idx] == lu_tag);
        pred_taken  = pred_hit && ctr_is_taken(ctr_mem[lu_idx]);
        pred_target = pred_hit ? {target_mem[lu_idx], 2'b00} : '0;
    end

    assign up_hit = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_n;
            clr_idx <= clr_idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_idx_n = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_n = clr_idx + 1'b1;
                if (clr_idx == IDX_W'(ENTRIES - 1)) state_n = IDLE;
            end
            IDLE: begin
                if (inv_req) begin
                    state_n   = CLEAR;
                    clr_idx_n = '0;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && (state == CLEAR)) begin
            valid_mem[clr_idx] <= 1'b0;
            ctr_mem[clr_idx]   <= WNT;
        end else if (update_en && !busy) begin
            if (up_hit) begin
                ctr_mem[up_idx] <= ctr_next(ctr_mem[up_idx], update_taken);
                if (update_taken) target_mem[up_idx] <= update_target[PC_W-1:2];
            end else if (update_taken) begin
                valid_mem[up_idx]  <= 1'b1;
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= update_target[PC_W-1:2];
                ctr_mem[up_idx]    <= WT;
            end
        end
    end

    bp_stat_counter #(.CNT_W(CNT_W)) u_lookup_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (lookup_en && !busy),
        .count (lookup_cnt)
    );

    bp_stat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (update_en && update_mispred && !busy),
        .count (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             lookup_en;
    logic [PC_W-1:0]  lookup_pc;
    logic             pred_hit, pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             update_en;
    logic [PC_W-1:0]  update_pc;
    logic             update_taken;
    logic [PC_W-1:0]  update_target;
    logic             update_mispred;
    logic             inv_req;
    logic             busy;
    logic [CNT_W-1:0] lookup_cnt, mispred_cnt;

    branch_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispred(update_mispred),
        .inv_req(inv_req), .busy(busy),
        .lookup_cnt(lookup_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: per-index records, counter as an integer 0..3, sweep as cycles remaining.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int          sweep_left = ENTRIES;
    int          m_lcnt = 0, m_mcnt = 0;
    bit          known = 0;

    logic        obs_hit, obs_taken, obs_busy;
    logic [31:0] obs_target, obs_lcnt, obs_mcnt;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (2 + IDX_W);
    endfunction

    function automatic bit m_busy();
        return !rst || (sweep_left > 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int i;
        bit h;
        if (!rst) begin
            sweep_left = ENTRIES;
            m_lcnt = 0;
            m_mcnt = 0;
            known = 1;
        end else if (sweep_left > 0) begin
            i = ENTRIES - sweep_left;
            m_valid[i] = 0;
            m_ctr[i] = 1;
            sweep_left--;
        end else begin
            if (lookup_en && m_lcnt < CNT_MAX) m_lcnt++;
            if (update_en && update_mispred && m_mcnt < CNT_MAX) m_mcnt++;
            if (update_en) begin
                i = idx_of(update_pc);
                h = m_valid[i] && (m_tag[i] == tag_of(update_pc));
                if (h) begin
                    if (update_taken) begin
                        if (m_ctr[i] < 3) m_ctr[i]++;
                        m_target[i] = update_target & 32'hFFFF_FFFC;
                    end else if (m_ctr[i] > 0) begin
                        m_ctr[i]--;
                    end
                end else if (update_taken) begin
                    m_valid[i]  = 1;
                    m_tag[i]    = tag_of(update_pc);
                    m_target[i] = update_target & 32'hFFFF_FFFC;
                    m_ctr[i]    = 2;
                end
            end
            if (inv_req) sweep_left = ENTRIES;
        end
    endtask

    task automatic tick();
        int i;
        bit hit;
        @(negedge clk);
        i   = idx_of(lookup_pc);
        hit = lookup_en && !m_busy() && m_valid[i] && (m_tag[i] == tag_of(lookup_pc));
        obs_hit = pred_hit; obs_taken = pred_taken; obs_target = pred_target; obs_busy = busy;
        obs_lcnt = 32'(lookup_cnt); obs_mcnt = 32'(mispred_cnt);
        check("busy", 32'(busy), 32'(m_busy()));
        check("pred_hit", 32'(pred_hit), 32'(hit));
        check("pred_taken", 32'(pred_taken), 32'(hit && (m_ctr[i] >= 2)));
        check("pred_target", pred_target, hit ? m_target[i] : 32'h0);
        if (known) begin
            check("lookup_cnt", obs_lcnt, 32'(m_lcnt));
            check("mispred_cnt", obs_mcnt, 32'(m_mcnt));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        lookup_en = 0; lookup_pc = '0;
        update_en = 0; update_pc = '0; update_taken = 0; update_target = '0; update_mispred = 0;
        inv_req = 0;
    endtask

    task automatic lu(input logic [31:0] pc);
        idle();
        lookup_en = 1; lookup_pc = pc;
        tick();
    endtask

    task automatic up(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic mis);
        idle();
        update_en = 1; update_pc = pc; update_taken = t; update_target = tgt; update_mispred = mis;
        tick();
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h4000_0000 | (32'($urandom_range(0, 3)) << 6)
             | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        idle();
        rst = 0;
        @(posedge clk);
        #1;

        repeat (3) lu(32'h100);
        rst = 1;
        for (int k = 0; k < ENTRIES; k++) begin
            lu(32'h100);
            check("sweep_busy", 32'(obs_busy), 32'h1);
        end
        lu(32'h100);
        check("sweep_done", 32'(obs_busy), 32'h0);
        check("reset_lcnt", obs_lcnt, 32'h0);
        check("reset_mcnt", obs_mcnt, 32'h0);

        up(32'h1000, 1, 32'h1083, 0);
        lu(32'h1000);
        check("alloc_hit", 32'(obs_hit), 32'h1);
        check("alloc_taken", 32'(obs_taken), 32'h1);
        check("alloc_target", obs_target, 32'h1080);
        up(32'h1000, 0, 32'h0, 1);
        lu(32'h1000);
        check("wnt_taken", 32'(obs_taken), 32'h0);
        check("wnt_hit", 32'(obs_hit), 32'h1);
        up(32'h1000, 0, 32'h0, 0);
        up(32'h1000, 0, 32'h0, 0);
        repeat (3) up(32'h1000, 1, 32'h1080, 0);
        lu(32'h1000);
        check("st_taken", 32'(obs_taken), 32'h1);

        up(32'h1040, 1, 32'h2000, 1);
        lu(32'h1000);
        check("alias_miss", 32'(obs_hit), 32'h0);
        lu(32'h1040);
        check("alias_hit", 32'(obs_hit), 32'h1);
        check("alias_target", obs_target, 32'h2000);
        up(32'h1004, 0, 32'h3000, 0);
        lu(32'h1004);
        check("nt_no_alloc", 32'(obs_hit), 32'h0);

        up(32'h1000, 1, 32'h1080, 0);
        up(32'h1000, 0, 32'h0, 0);
        idle();
        lookup_en = 1; lookup_pc = 32'h1000;
        update_en = 1; update_pc = 32'h1000; update_taken = 1; update_target = 32'h1080;
        tick();
        check("same_cycle_old", 32'(obs_taken), 32'h0);
        lu(32'h1000);
        check("same_cycle_new", 32'(obs_taken), 32'h1);

        for (int k = 0; k < 300; k++) begin
            idle();
            lookup_en      = 1'($urandom_range(0, 1));
            lookup_pc      = rand_pc();
            update_en      = 1'($urandom_range(0, 1));
            update_pc      = rand_pc();
            update_taken   = 1'($urandom_range(0, 1));
            update_target  = $urandom;
            update_mispred = 1'($urandom_range(0, 1));
            inv_req        = ($urandom_range(0, 39) == 0);
            tick();
        end
        idle();
        for (int k = 0; k <= ENTRIES && sweep_left > 0; k++) tick();

        up(32'h1000, 1, 32'h1080, 0);
        idle(); inv_req = 1; tick();
        for (int k = 0; k < ENTRIES; k++) begin
            idle();
            if (k == 2) begin
                update_en = 1; update_pc = 32'h3000; update_taken = 1; update_target = 32'h3100;
            end
            if (k == 5) inv_req = 1;
            tick();
            check("inv_busy", 32'(obs_busy), 32'h1);
        end
        lu(32'h1000);
        check("inv_miss_a", 32'(obs_hit), 32'h0);
        check("inv_done", 32'(obs_busy), 32'h0);
        lu(32'h3000);
        check("inv_drop", 32'(obs_hit), 32'h0);

        idle(); inv_req = 1; tick();
        idle();
        repeat (5) tick();
        rst = 0; tick();
        rst = 1;
        for (int k = 0; k < ENTRIES; k++) begin
            tick();
            check("restart_busy", 32'(obs_busy), 32'h1);
        end
        tick();
        check("restart_done", 32'(obs_busy), 32'h0);

        for (int k = 0; k < 20; k++) up(rand_pc(), 1'($urandom_range(0, 1)), $urandom, 1);
        idle(); tick();
        check("mcnt_sat", obs_mcnt, 32'd15);
        idle(); inv_req = 1; tick();
        repeat (3) lu(32'h100);
        idle();
        repeat (ENTRIES - 3) tick();
        repeat (17) lu(rand_pc());
        idle(); tick();
        check("lcnt_sat", obs_lcnt, 32'd15);
        idle(); inv_req = 1; tick();
        idle(); tick();
        check("inv_keep_l", obs_lcnt, 32'd15);
        check("inv_keep_m", obs_mcnt, 32'd15);
        repeat (ENTRIES) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
